// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative divider.
//   - div_state_e : FSM state codes (IDLE, RUN, FIX)
//   - DIV_STEPS   : number of restoring steps (one per quotient bit)
//   - DIV_ZERO_QUOT : quotient produced for a zero divisor
//   - mag()       : two's-complement magnitude helper
package div_unit_pkg;

  localparam int DIV_W = 32;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] DIV_LAST_STEP = CNT_W'(DIV_STEPS - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  // Magnitude of v when neg is set, v unchanged otherwise.
  // 0x80000000 maps to itself, which reads correctly as unsigned 2^31.
  function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// div_unit_step: one combinational restoring-division step.
// Ports:
//   rem      in  33  partial remainder
//   q        in  32  dividend bits still to shift in / quotient bits so far
//   divisor  in  32  divisor magnitude
//   rem_next out 33  partial remainder after this step
//   q_next   out 32  quotient/dividend register after this step
module div_unit_step
  import div_unit_pkg::*;
(
  input  logic [32:0]      rem,
  input  logic [DIV_W-1:0] q,
  input  logic [DIV_W-1:0] divisor,
  output logic [32:0]      rem_next,
  output logic [DIV_W-1:0] q_next
);

  logic [32:0] rem_shift;
  logic [32:0] dvs_ext;
  logic        fits;

  always_comb begin
    // Bring the next dividend bit (MSB of q) into the remainder.
    rem_shift = {rem[31:0], q[31]};
    dvs_ext   = {1'b0, divisor};
    fits      = (rem_shift >= dvs_ext);
    rem_next  = fits ? (rem_shift - dvs_ext) : rem_shift;
    q_next    = {q[30:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit MIPS DIV/DIVU unit (HI = remainder, LO = quotient).
// Ports:
//   clock, reset  sole clock; synchronous active-high reset
//   start         request a divide (accepted only in IDLE, not in a done cycle)
//   is_signed     1 = DIV, 0 = DIVU (sampled with start)
//   dividend      rs value (sampled with start)
//   divisor       rt value (sampled with start)
//   busy          registered; high from acceptance until the result is written
//   done          one-cycle pulse; div_hi/div_lo valid in that cycle
//   div_hi        remainder, held until the next completion
//   div_lo        quotient, held until the next completion
//   dbg_state     current FSM state (div_state_e encoding)
// Handshake: start is a request level sampled on a rising edge only while
// the FSM is IDLE and done is low; there is no back-pressure beyond busy,
// and the result is valid exactly in the cycle done is high.
module div_unit
  import div_unit_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] div_hi,
  output logic [DIV_W-1:0] div_lo,
  output logic [1:0]       dbg_state
);

  div_state_e state, next_state;

  logic [CNT_W-1:0] count;
  logic [32:0]      rem;
  logic [DIV_W-1:0] q;
  logic [DIV_W-1:0] dvs_mag;
  logic [DIV_W-1:0] orig_dividend;
  logic             op_signed;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;

  logic [32:0]      rem_next;
  logic [DIV_W-1:0] q_next;
  logic             accept;
  logic [DIV_W-1:0] quot_fixed;
  logic [DIV_W-1:0] rem_fixed;

  // A start seen while the previous result is still being presented is
  // ignored so that one request cannot collide with the completion cycle.
  assign accept    = (state == DIV_IDLE) && start && !done;
  assign dbg_state = state;

  div_unit_step u_step (
    .rem      (rem),
    .q        (q),
    .divisor  (dvs_mag),
    .rem_next (rem_next),
    .q_next   (q_next)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= DIV_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      DIV_IDLE: if (accept) next_state = DIV_RUN;
      DIV_RUN:  if (count == DIV_LAST_STEP) next_state = DIV_FIX;
      DIV_FIX:  next_state = DIV_IDLE;
      default:  next_state = DIV_IDLE;
    endcase
  end

  // Truncating-division sign fixup: quotient negative when signs differ,
  // remainder follows the dividend. Zero divisor overrides both.
  always_comb begin
    quot_fixed = (op_signed && (dvd_neg ^ dvs_neg)) ? (32'd0 - q) : q;
    rem_fixed  = (op_signed && dvd_neg) ? (32'd0 - rem[31:0]) : rem[31:0];
    if (dvs_zero) begin
      quot_fixed = DIV_ZERO_QUOT;
      rem_fixed  = orig_dividend;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count         <= '0;
      rem           <= '0;
      q             <= '0;
      dvs_mag       <= '0;
      orig_dividend <= '0;
      op_signed     <= 1'b0;
      dvd_neg       <= 1'b0;
      dvs_neg       <= 1'b0;
      dvs_zero      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      div_hi        <= '0;
      div_lo        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            op_signed     <= is_signed;
            dvd_neg       <= is_signed & dividend[31];
            dvs_neg       <= is_signed & divisor[31];
            dvs_zero      <= (divisor == '0);
            orig_dividend <= dividend;
            q             <= mag(dividend, is_signed & dividend[31]);
            dvs_mag       <= mag(divisor, is_signed & divisor[31]);
            rem           <= '0;
            count         <= '0;
            busy          <= 1'b1;
          end
        end
        DIV_RUN: begin
          rem   <= rem_next;
          q     <= q_next;
          count <= count + 1'b1;
        end
        DIV_FIX: begin
          div_hi <= rem_fixed;
          div_lo <= quot_fixed;
          done   <= 1'b1;
          busy   <= 1'b0;
          count  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit. Directed corner cases plus
// randomized operands compared against an arithmetic reference model.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];

  div_unit dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_hi    (div_hi),
    .div_lo    (div_lo),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU from plain arithmetic. SV integer / and %
  // truncate toward zero, matching MIPS.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] quo, output logic [31:0] rmd);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rmd = a;
    end else if (s) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lq  = sa / sb;
      lr  = sa % sb;
      quo = lq[31:0];
      rmd = lr[31:0];
    end else begin
      quo = a / b;
      rmd = a % b;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Called at the negedge right after the accepting edge (lat = 0).
  // Optionally pulses a stray start at RUN cycle inject_at.
  task automatic wait_done(input int inject_at, output int lat, output int busy_cnt,
                           output logic seen);
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat <= 60) begin
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else begin
        if (lat == inject_at) begin
          start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd4;
        end else begin
          start = 1'b0;
        end
        @(negedge clock);
        lat++;
      end
    end
    start = 1'b0;
  endtask

  // Full transaction: issue, wait, compare against the queued expectation.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int inject_at);
    logic [31:0] eq, er, got_q, got_r;
    int lat, bc;
    logic seen;
    ref_div(s, a, b, eq, er);
    exp_q.push_back(eq);
    exp_q.push_back(er);
    issue(s, a, b);
    wait_done(inject_at, lat, bc, seen);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd33);
    check({tag, "_busy_cycles"}, 32'(bc), 32'd33);
    got_q = exp_q.pop_front();
    got_r = exp_q.pop_front();
    check({tag, "_lo"}, div_lo, got_q);
    check({tag, "_hi"}, div_hi, got_r);
    @(negedge clock);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_lo_hold"}, div_lo, got_q);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ra, rb, eq, er;
    logic        rs, seen;
    int          lat, bc, sel;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", div_hi, 32'd0);
    check("rst_lo", div_lo, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    run_op("u100_7", 1'b0, 32'd100, 32'd7, -1);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("u_div0", 1'b0, 32'd1234, 32'd0, -1);
    run_op("s_div0", 1'b1, 32'd1234, 32'd0, -1);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("u_big", 1'b0, 32'hFFFF_FFFF, 32'd1, -1);
    run_op("s_negneg", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1);
    // Stray start mid-operation must not disturb 20/3.
    run_op("midstart", 1'b0, 32'd20, 32'd3, 5);

    // Start held across the done cycle: ignored there, accepted one cycle later.
    issue(1'b0, 32'd77, 32'd10);
    wait_done(-1, lat, bc, seen);
    check("coinc_first_done", 32'(seen), 32'd1);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd45; divisor = 32'd6;
    @(negedge clock);
    check("coinc_ignored", 32'(busy), 32'd0);
    @(negedge clock);
    start = 1'b0;
    check("coinc_accepted", 32'(busy), 32'd1);
    wait_done(-1, lat, bc, seen);
    check("coinc_latency", 32'(lat), 32'd33);
    check("coinc_lo", div_lo, 32'd7);
    check("coinc_hi", div_hi, 32'd3);

    // Reset during RUN clears everything with no done pulse.
    issue(1'b0, 32'd999, 32'd7);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_hi", div_hi, 32'd0);
    check("midrst_lo", div_lo, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    bc = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) bc++;
    end
    check("midrst_no_done", 32'(bc), 32'd0);
    run_op("post_rst", 1'b0, 32'd50, 32'd5, -1);

    // Randomized operands with a bias toward awkward values.
    for (int i = 0; i < 30; i++) begin
      rs  = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) rb = 32'($urandom_range(1, 15));
      else if (sel == 2) rb = 32'hFFFF_FFFF;
      else if (sel == 3) ra = 32'h8000_0000;
      ref_div(rs, ra, rb, eq, er);
      issue(rs, ra, rb);
      wait_done(-1, lat, bc, seen);
      check($sformatf("rnd%0d_lo", i), div_lo, eq);
      check($sformatf("rnd%0d_hi", i), div_hi, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
